// File: rtl/iomem_arbiter.sv
// iomem_arbiter: two-master round-robin arbiter onto a single iomem-style
// peripheral bus. One transaction is in flight at a time; the owner is held
// until the slave answers, the owner abandons, or (optionally) a timeout fires.
//
// Optional feature: define IOMEM_ARB_TIMEOUT_EN to force-complete a granted
// transaction after TIMEOUT_CYCLES cycles without s_ready. Default build has
// no timeout counter and timeout_err is tied low.
//
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   m0_*/m1_* valid/addr/wdata/wstrb master requests (wstrb 0 = read)
//   m0_ready/m1_ready, *_rdata      completion pulse and read data per master
//   s_valid/s_addr/s_wdata/s_wstrb  shared peripheral request
//   s_ready/s_rdata                 peripheral completion and read data
//   grant                           one-hot owner (01 = m0, 10 = m1, 00 = idle)
//   timeout_err                     pulse when a transaction is force-completed
//
// State table:
//   IDLE  | no owner; arbitrate between pending requests
//   BUSY0 | m0 owns the peripheral bus
//   BUSY1 | m1 owns the peripheral bus
module iomem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;  // 0 = m0 served last, 1 = m1
  logic   busy0, busy1, own_valid, timeout_hit;
  logic [31:0] rdata_sel;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("iomem_arbiter: TIMEOUT_CYCLES must be in 2..255");
  end

  assign busy0     = (state == BUSY0);
  assign busy1     = (state == BUSY1);
  assign own_valid = (busy0 & m0_valid) | (busy1 & m1_valid);

`ifdef IOMEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt;

  // A real completion in the same cycle wins over the timeout.
  assign timeout_hit = own_valid && !s_ready && (to_cnt == TO_LAST);

  // Counts cycles the current owner has waited; zero on every BUSY entry.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      to_cnt <= 8'd0;
    end else if (state != IDLE && state_nxt == state) begin
      to_cnt <= to_cnt + 8'd1;
    end else begin
      to_cnt <= 8'd0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          state_nxt = last_grant ? BUSY0 : BUSY1;
        end else if (m0_valid) begin
          state_nxt = BUSY0;
        end else if (m1_valid) begin
          state_nxt = BUSY1;
        end
      end
      BUSY0, BUSY1: begin
        // Completion, abandon and timeout all release the bus and count as a turn.
        if (s_ready || !own_valid || timeout_hit) begin
          state_nxt      = IDLE;
          last_grant_nxt = (state == BUSY1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rdata_sel = timeout_hit ? TIMEOUT_RDATA : s_rdata;

  always_comb begin
    s_valid = own_valid & ~timeout_hit;
    s_addr  = 32'd0;
    s_wdata = 32'd0;
    s_wstrb = 4'd0;
    if (busy0) begin
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
      s_wstrb = m0_wstrb;
    end else if (busy1) begin
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_wstrb = m1_wstrb;
    end
  end

  assign m0_ready    = busy0 & (s_ready | timeout_hit);
  assign m1_ready    = busy1 & (s_ready | timeout_hit);
  assign m0_rdata    = busy0 ? rdata_sel : 32'd0;
  assign m1_rdata    = busy1 ? rdata_sel : 32'd0;
  assign grant       = {busy1, busy0};
  assign timeout_err = timeout_hit;

endmodule

// File: tb/tb_iomem_arbiter.sv
module tb_iomem_arbiter;

  localparam int          TO    = 8;
  localparam logic [31:0] TO_RD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        mv [2];
  logic [31:0] ma [2];
  logic [31:0] mw [2];
  logic [3:0]  ms [2];

  logic        m0_valid, m1_valid, m0_ready, m1_ready;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        s_valid, s_ready, timeout_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;

  assign m0_valid = mv[0];
  assign m1_valid = mv[1];
  assign m0_addr  = ma[0];
  assign m1_addr  = ma[1];
  assign m0_wdata = mw[0];
  assign m1_wdata = mw[1];
  assign m0_wstrb = ms[0];
  assign m1_wstrb = ms[1];

  iomem_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_RDATA(TO_RD)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus (0 none, 1 m0, 2 m1), who was served
  // last, and how many cycles the current owner has been waiting.
  int       own  = 0;
  int       last = 2;
  int       age  = 0;
  bit       to_now;
  bit [1:0] rdy_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic eval();
    logic [31:0] ea, ew, es, rd;
    bit ov;
    #1;
    ov = (own != 0) && mv[own-1];
    to_now = 1'b0;
`ifdef IOMEM_ARB_TIMEOUT_EN
    to_now = ov && !s_ready && (age == TO - 1);
`endif
    ea = (own != 0) ? ma[own-1] : 32'd0;
    ew = (own != 0) ? mw[own-1] : 32'd0;
    es = (own != 0) ? 32'(ms[own-1]) : 32'd0;
    rd = to_now ? TO_RD : s_rdata;
    rdy_exp[0] = (own == 1) && (s_ready || to_now);
    rdy_exp[1] = (own == 2) && (s_ready || to_now);
    chk("grant",       32'(grant),       32'(own));
    chk("s_valid",     32'(s_valid),     32'(ov && !to_now));
    chk("s_addr",      s_addr,           ea);
    chk("s_wdata",     s_wdata,          ew);
    chk("s_wstrb",     32'(s_wstrb),     es);
    chk("m0_ready",    32'(m0_ready),    32'(rdy_exp[0]));
    chk("m1_ready",    32'(m1_ready),    32'(rdy_exp[1]));
    chk("m0_rdata",    m0_rdata,         (own == 1) ? rd : 32'd0);
    chk("m1_rdata",    m1_rdata,         (own == 2) ? rd : 32'd0);
    chk("timeout_err", 32'(timeout_err), 32'(to_now));
  endtask

  task automatic adv();
    if (!resetn) begin
      own = 0; last = 2; age = 0;
    end else if (own == 0) begin
      if (mv[0] && mv[1]) own = (last == 2) ? 1 : 2;
      else if (mv[0])     own = 1;
      else if (mv[1])     own = 2;
      age = 0;
    end else if (s_ready || !mv[own-1] || to_now) begin
      last = own; own = 0; age = 0;
    end else begin
      age++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int exp30 [8];
    exp30 = '{0, 1, 0, 2, 0, 1, 0, 2};
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; ma[i] = 32'd0; mw[i] = 32'd0; ms[i] = 4'd0;
    end
    s_ready = 1'b0; s_rdata = 32'd0; resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset state
    eval();
    chk("rst_grant",   32'(grant),       32'd0);
    chk("rst_s_valid", 32'(s_valid),     32'd0);
    chk("rst_m0_rdy",  32'(m0_ready),    32'd0);
    chk("rst_m1_rdy",  32'(m1_ready),    32'd0);
    chk("rst_to_err",  32'(timeout_err), 32'd0);
    adv();
    resetn = 1'b1;

    // Single m0 read, slave answers one cycle after s_valid
    mv[0] = 1'b1; ma[0] = 32'h0300_0000; mw[0] = 32'd0; ms[0] = 4'd0;
    eval();
    chk("r29_idle_grant",  32'(grant),   32'd0);
    chk("r29_idle_svalid", 32'(s_valid), 32'd0);
    adv();
    eval();
    chk("r29_grant",  32'(grant),    32'd1);
    chk("r29_svalid", 32'(s_valid),  32'd1);
    chk("r29_saddr",  s_addr,        32'h0300_0000);
    chk("r29_m0rdy0", 32'(m0_ready), 32'd0);
    adv();
    s_ready = 1'b1; s_rdata = 32'h0000_0001;
    eval();
    chk("r29_m0rdy",  32'(m0_ready), 32'd1);
    chk("r29_m0data", m0_rdata,      32'h0000_0001);
    chk("r29_m1rdy",  32'(m1_ready), 32'd0);
    adv();
    mv[0] = 1'b0; s_ready = 1'b0; s_rdata = 32'd0;
    eval();
    chk("r29_after_grant", 32'(grant),    32'd0);
    chk("r29_after_m0rdy", 32'(m0_ready), 32'd0);
    adv();

    // Continuous tie after reset alternates owners
    resetn = 1'b0;
    eval();
    adv();
    resetn = 1'b1;
    mv[0] = 1'b1; mv[1] = 1'b1; s_ready = 1'b1; s_rdata = 32'h1234_5678;
    ma[1] = 32'h0300_0020; mw[1] = 32'd0; ms[1] = 4'd0;
    for (int k = 0; k < 8; k++) begin
      eval();
      chk($sformatf("r30_seq%0d", k), 32'(grant), 32'(exp30[k]));
      adv();
    end
    mv[0] = 1'b0; mv[1] = 1'b0; s_ready = 1'b0;
    eval();
    adv();

    // m1 write waits while m0 is busy
    mv[0] = 1'b1; ma[0] = 32'h0300_0004; ms[0] = 4'd0;
    eval();
    adv();
    mv[1] = 1'b1; ma[1] = 32'h0300_0010; mw[1] = 32'h0000_00A5; ms[1] = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      eval();
      chk("r31_hold_grant", 32'(grant),    32'd1);
      chk("r31_hold_m1rdy", 32'(m1_ready), 32'd0);
      adv();
    end
    s_ready = 1'b1;
    eval();
    chk("r31_m0rdy", 32'(m0_ready), 32'd1);
    chk("r31_m1rdy", 32'(m1_ready), 32'd0);
    adv();
    mv[0] = 1'b0; s_ready = 1'b0;
    eval();
    chk("r31_gap_grant",  32'(grant),   32'd0);
    chk("r31_gap_svalid", 32'(s_valid), 32'd0);
    adv();
    eval();
    chk("r31_grant",  32'(grant),   32'd2);
    chk("r31_svalid", 32'(s_valid), 32'd1);
    chk("r31_wdata",  s_wdata,      32'h0000_00A5);
    chk("r31_wstrb",  32'(s_wstrb), 32'd1);
    adv();
    s_ready = 1'b1;
    eval();
    chk("r31_m1rdy_done", 32'(m1_ready), 32'd1);
    adv();
    mv[1] = 1'b0; s_ready = 1'b0;

    // Reset during BUSY1 aborts silently; next tie goes to m0
    mv[1] = 1'b1;
    eval();
    adv();
    eval();
    chk("r33_busy1", 32'(grant), 32'd2);
    adv();
    resetn = 1'b0;
    eval();
    chk("r33_rst_m1rdy", 32'(m1_ready), 32'd0);
    adv();
    resetn = 1'b1; mv[0] = 1'b1;
    eval();
    chk("r33_grant",  32'(grant),    32'd0);
    chk("r33_svalid", 32'(s_valid),  32'd0);
    chk("r33_m1rdy",  32'(m1_ready), 32'd0);
    adv();
    eval();
    chk("r33_tie_m0", 32'(grant), 32'd1);
    adv();
    mv[0] = 1'b0; mv[1] = 1'b0;
    eval();
    adv();

    // Slave never ready
    mv[0] = 1'b1; ma[0] = 32'h0300_0040; ms[0] = 4'd0; s_ready = 1'b0;
    eval();
    adv();
`ifdef IOMEM_ARB_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      eval();
      chk("r32_m0rdy",  32'(m0_ready),    32'(k == TO - 1));
      chk("r32_to_err", 32'(timeout_err), 32'(k == TO - 1));
      chk("r32_svalid", 32'(s_valid),     32'(k != TO - 1));
      if (k == TO - 1) chk("r32_rdata", m0_rdata, 32'hDEAD_BEEF);
      adv();
    end
    mv[0] = 1'b0;
    eval();
    chk("r32_idle", 32'(grant), 32'd0);
    adv();
`else
    for (int k = 0; k < 300; k++) begin
      eval();
      adv();
    end
    eval();
    chk("r32_still_busy0", 32'(grant),       32'd1);
    chk("r32_no_to_err",   32'(timeout_err), 32'd0);
    adv();
    mv[0] = 1'b0;
    eval();
    adv();
    eval();
    chk("r32_abandon_idle", 32'(grant), 32'd0);
    adv();
`endif

    // Randomized traffic against the model
    rdy_exp = 2'b00;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (mv[i] && rdy_exp[i]) begin
          mv[i] = 1'b0;
        end else if (mv[i] && $urandom_range(29) == 0) begin
          mv[i] = 1'b0;
        end else if (!mv[i] && $urandom_range(2) == 0) begin
          mv[i] = 1'b1;
          ma[i] = $urandom;
          mw[i] = $urandom;
          ms[i] = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
        end
      end
      s_ready = ($urandom_range(4) < 2);
      s_rdata = $urandom;
      resetn  = ($urandom_range(199) != 0);
      eval();
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
